// File: rtl/synth_voice_pkg.sv
// rtl/synth_voice_pkg.sv - shared types, LFSR constants and quarter-wave sine table for synth_voice
package synth_voice_pkg;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

    typedef enum logic [2:0] {
        WAVE_PULSE = 3'b000,
        WAVE_TRI   = 3'b001,
        WAVE_SINE  = 3'b010,
        WAVE_SAW   = 3'b011,
        WAVE_NOISE = 3'b100
    } wave_sel_t;

    // x^15 + x^14 + 1: feedback taps are the two top bits of a left-shifting register
    localparam logic [14:0] LFSR_SEED  = 15'h7FFF;
    localparam int          LFSR_TAP_A = 14;
    localparam int          LFSR_TAP_B = 13;

    // round(127*sin(pi*i/128)) for i = 0..63; entry 64 (the peak, 127) is implied
    localparam logic [6:0] SINE_QUARTER [0:63] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
    };

endpackage

// File: rtl/synth_voice_sine_lut.sv
// rtl/synth_voice_sine_lut.sv - combinational 8-bit sine lookup folded from a quarter-wave table
module synth_voice_sine_lut
    import synth_voice_pkg::*;
(
    input  logic [7:0] idx,
    output logic [7:0] value
);

    logic [5:0] k;
    logic [6:0] mag;

    // Quadrants 1 and 3 mirror the table; their k=0 point is the peak, which the table omits
    always_comb begin
        k   = idx[5:0];
        mag = 7'd0;
        if (!idx[6]) begin
            mag = SINE_QUARTER[k];
        end else if (k == 6'd0) begin
            mag = 7'd127;
        end else begin
            mag = SINE_QUARTER[6'd0 - k];
        end
        if (idx[7]) begin
            value = 8'd128 - {1'b0, mag};
        end else begin
            value = 8'd128 + {1'b0, mag};
        end
    end

endmodule

// File: rtl/synth_voice.sv
// rtl/synth_voice.sv - phase-accumulator voice with ASR envelope; noise source under SYNTH_VOICE_NOISE_EN
module synth_voice
    import synth_voice_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int INC_W   = 16,
    parameter int OUT_W   = 11,
    parameter int ENV_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic [INC_W-1:0]   phase_inc,
    input  logic [2:0]         waveform,
    input  logic [7:0]         duty,
    input  logic               gate,
    input  logic [ENV_W-1:0]   attack_rate,
    input  logic [ENV_W-1:0]   release_rate,
    input  logic [ENV_W-1:0]   sustain_level,
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic [1:0]         env_state,
    output logic               busy
);

    localparam int              PW  = OUT_W + ENV_W + 2;
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PHASE_W-1:0] phase;
    logic [7:0]         idx;
    logic [7:0]         sine_val;
    logic [7:0]         raw8;
    logic [OUT_W-1:0]   raw_full;
    logic signed [OUT_W:0] diff;
    logic signed [PW-1:0]  prod;
    logic [OUT_W-1:0]   out_next;
    logic               unused_prod;

    env_state_t         env_q;
    logic [ENV_W-1:0]   level;
    logic [ENV_W:0]     attack_sum;

    assign idx = phase[PHASE_W-1 -: 8];

    synth_voice_sine_lut u_sine (
        .idx   (idx),
        .value (sine_val)
    );

`ifdef SYNTH_VOICE_NOISE_EN
    logic [14:0] lfsr;

    // Noise register steps once per sample regardless of the selected waveform
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (sample_tick) begin
            lfsr <= {lfsr[13:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
        end
    end
`endif

    // Phase accumulator; the increment is zero-extended and wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (sample_tick) begin
            phase <= phase + PHASE_W'(phase_inc);
        end
    end

    // Select the 8-bit shape; unknown codes sit at midscale so the voice is silent
    always_comb begin
        raw8 = 8'h80;
        case (waveform)
            WAVE_PULSE: raw8 = (idx < duty) ? 8'hFF : 8'h00;
            WAVE_TRI:   raw8 = idx[7] ? {~idx[6:0], 1'b0} : {idx[6:0], 1'b0};
            WAVE_SINE:  raw8 = sine_val;
            WAVE_SAW:   raw8 = idx;
`ifdef SYNTH_VOICE_NOISE_EN
            WAVE_NOISE: raw8 = lfsr[14:7];
`endif
            default:    raw8 = 8'h80;
        endcase
    end

    // Scale the signed deviation from midscale by the envelope level (floor division by 2^ENV_W)
    assign raw_full    = OUT_W'(raw8) << (OUT_W - 8);
    assign diff        = $signed({1'b0, raw_full}) - $signed({1'b0, MID});
    assign prod        = PW'(diff) * PW'($signed({1'b0, level}));
    assign out_next    = MID + prod[ENV_W +: OUT_W];
    assign unused_prod = ^{prod[ENV_W-1:0], prod[PW-1:OUT_W+ENV_W]};

    assign attack_sum  = {1'b0, level} + {1'b0, attack_rate};

    // Envelope FSM: saturating attack to sustain, tracking sustain, release to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q <= ENV_IDLE;
            level <= '0;
            busy  <= 1'b0;
        end else if (sample_tick) begin
            case (env_q)
                ENV_IDLE: begin
                    if (gate) begin
                        env_q <= ENV_ATTACK;
                        busy  <= 1'b1;
                    end
                end
                ENV_ATTACK: begin
                    if (!gate) begin
                        env_q <= ENV_RELEASE;
                    end else if (attack_sum >= {1'b0, sustain_level}) begin
                        level <= sustain_level;
                        env_q <= ENV_SUSTAIN;
                    end else begin
                        level <= attack_sum[ENV_W-1:0];
                    end
                end
                ENV_SUSTAIN: begin
                    level <= sustain_level;
                    if (!gate) begin
                        env_q <= ENV_RELEASE;
                    end
                end
                ENV_RELEASE: begin
                    if (gate) begin
                        env_q <= ENV_ATTACK;
                    end else if (level <= release_rate) begin
                        level <= '0;
                        env_q <= ENV_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        level <= level - release_rate;
                    end
                end
                default: begin
                    env_q <= ENV_IDLE;
                    level <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign env_state = env_q;

    // Output sample register, built from the state as it was before this tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= MID;
            out_valid <= 1'b0;
        end else begin
            out_valid <= sample_tick;
            if (sample_tick) begin
                out <= out_next;
            end
        end
    end

endmodule
